// File: rtl/sdp_ram_ctrl.sv
// Clear sequencer, round-robin write arbiter and write-first read port for a
// simple dual-port RAM.
//
// state | meaning
// CLEAR | zero every RAM word, requesters held off
// RUN   | arbitrate writes, serve reads
module sdp_ram_ctrl #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DATA_DEPTH = 256,
    localparam int AW         = $clog2(DATA_DEPTH)
) (
    input  logic                  clka,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  busy,
    input  logic                  w0_valid,
    input  logic [AW-1:0]         w0_addr,
    input  logic [DATA_WIDTH-1:0] w0_data,
    output logic                  w0_ready,
    input  logic                  w1_valid,
    input  logic [AW-1:0]         w1_addr,
    input  logic [DATA_WIDTH-1:0] w1_data,
    output logic                  w1_ready,
    input  logic                  rd_valid,
    input  logic [AW-1:0]         rd_addr,
    output logic                  rd_ready,
    output logic                  rd_dvalid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_wen,
    output logic [AW-1:0]         ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic [AW-1:0]         ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DATA_DEPTH - 1);

    state_t                  state_q, state_d;
    logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
    logic                    pri_q, pri_d;
    logic                    rd_dvalid_q;
    logic                    hit_q;
    logic [DATA_WIDTH-1:0]   byp_q;
    logic                    rd_fire;
    logic                    hit;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= '0;
            pri_q       <= 1'b0;
            rd_dvalid_q <= 1'b0;
            hit_q       <= 1'b0;
            byp_q       <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            pri_q       <= pri_d;
            rd_dvalid_q <= rd_fire;
            hit_q       <= hit;
            if (hit) begin
                byp_q <= ram_w_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        pri_d      = pri_q;
        busy       = 1'b0;
        w0_ready   = 1'b0;
        w1_ready   = 1'b0;
        rd_ready   = 1'b0;
        ram_wen    = 1'b0;
        ram_w_addr = '0;
        ram_w_data = '0;
        ram_r_addr = '0;
        case (state_q)
            CLEAR: begin
                busy       = 1'b1;
                ram_wen    = 1'b1;
                ram_w_addr = clr_cnt_q;
                if (clr_req) begin
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                rd_ready   = 1'b1;
                ram_r_addr = rd_addr;
                // A clear request wins over any grant in the same cycle.
                if (clr_req) begin
                    state_d = CLEAR;
                end else if (w0_valid && w1_valid) begin
                    pri_d = ~pri_q;
                    if (pri_q) begin
                        w1_ready = 1'b1;
                    end else begin
                        w0_ready = 1'b1;
                    end
                end else if (w0_valid) begin
                    w0_ready = 1'b1;
                end else if (w1_valid) begin
                    w1_ready = 1'b1;
                end
                if (w0_ready) begin
                    ram_wen    = 1'b1;
                    ram_w_addr = w0_addr;
                    ram_w_data = w0_data;
                end else if (w1_ready) begin
                    ram_wen    = 1'b1;
                    ram_w_addr = w1_addr;
                    ram_w_data = w1_data;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    assign rd_fire = rd_valid && rd_ready;
    // The RAM returns pre-write data on a same-address collision, so forward the write.
    assign hit     = rd_fire && ram_wen && (ram_w_addr == rd_addr);

    assign rd_dvalid = rd_dvalid_q;
    assign rd_data   = hit_q ? byp_q : (rd_dvalid_q ? ram_r_data : '0);

endmodule
